rvm_ifu: RTL and testbench

Instruction fetch unit for the multi-cycle core. It reads the current program counter from the PC unit and fetches the instruction word over a request/grant/response memory port. It presents the instruction to decode with a valid/ready handshake. It drives the PC unit's write interface (pc_w_en/pc_wdata) to advance sequentially or to apply a redirect from execute.

---
 rtl/rvm_ifu.sv | 179 +++++++++++++++++
 tb/tb_rvm_ifu.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvm_ifu.sv
// Purpose : instruction fetch unit; fetches the word at pc over a req/gnt/rvalid port and hands it to decode.
// Latency : 3 cycles per instruction with zero-wait memory (REQ+gnt, WAIT+rvalid, HOLD+ready).
// Backpressure: holds the fetched instruction stable while instr_ready is low; one request outstanding at most.
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   pc                          current PC from the PC unit
//   pc_w_en, pc_wdata           PC write: 01 sequential (pc+4), 10 redirect target
//   imem_req/addr/gnt           fetch request channel
//   imem_rvalid/rdata/err       fetch response channel
//   instr_valid/data/pc/ready   decode handshake
//   redirect_valid/target       redirect request from execute
//   fetch_fault, fault_cause    sticky fault: 01 misaligned PC, 10 bus error

module rvm_ifu #(
    parameter logic [31:0] INSTR_NOP         = 32'h00000013,
    parameter int unsigned FAULT_ON_MISALIGN = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] pc,
    output logic [1:0]  pc_w_en,
    output logic [31:0] pc_wdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err,
    output logic        instr_valid,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        fetch_fault,
    output logic [1:0]  fault_cause
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t      r_state;
    logic        r_squash;
    logic        r_instr_valid;
    logic [31:0] r_instr_data;
    logic [31:0] r_instr_pc;
    logic        r_fetch_fault;
    logic [1:0]  r_fault_cause;

    logic        w_misalign;
    logic        w_req;
    logic        w_granted;
    logic        w_accept;
    logic [31:0] w_addr;

    // A misaligned PC is only a fault when the parameter asks for it;
    // otherwise the low bits are simply dropped from the fetch address.
    assign w_misalign = (FAULT_ON_MISALIGN != 0) && (pc[1:0] != 2'b00);
    assign w_addr     = (FAULT_ON_MISALIGN != 0) ? pc : {pc[31:2], 2'b00};
    assign w_req      = (r_state == S_REQ) && !w_misalign;
    // gnt only counts while a request is actually being presented
    assign w_granted  = w_req && imem_gnt;
    assign w_accept   = (r_state == S_HOLD) && instr_ready;

    assign imem_req    = w_req;
    assign imem_addr   = w_addr;
    assign instr_valid = r_instr_valid;
    assign instr_data  = r_instr_data;
    assign instr_pc    = r_instr_pc;
    assign fetch_fault = r_fetch_fault;
    assign fault_cause = r_fault_cause;

    // PC write is combinational so the PC unit applies it at the same edge
    // the FSM moves, and the following REQ sees the updated pc.
    always_comb begin
        pc_w_en  = 2'b00;
        pc_wdata = 32'd0;
        if (redirect_valid) begin
            pc_w_en  = 2'b10;
            pc_wdata = redirect_target;
        end else if (w_accept) begin
            pc_w_en  = 2'b01;
            pc_wdata = pc + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= S_IDLE;
            r_squash      <= 1'b0;
            r_instr_valid <= 1'b0;
            r_instr_data  <= INSTR_NOP;
            r_instr_pc    <= 32'd0;
            r_fetch_fault <= 1'b0;
            r_fault_cause <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_REQ;
                end

                S_REQ: begin
                    if (redirect_valid) begin
                        // A request granted this cycle targets the old PC; its
                        // response must be thrown away.
                        if (w_granted) begin
                            r_squash <= 1'b1;
                            r_state  <= S_WAIT;
                        end
                    end else if (w_misalign) begin
                        r_fetch_fault <= 1'b1;
                        r_fault_cause <= 2'b01;
                        r_state       <= S_FAULT;
                    end else if (w_granted) begin
                        r_state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (redirect_valid) begin
                        if (imem_rvalid) begin
                            r_squash     <= 1'b0;
                            r_instr_data <= INSTR_NOP;
                            r_state      <= S_REQ;
                        end else begin
                            r_squash <= 1'b1;
                        end
                    end else if (imem_rvalid) begin
                        if (r_squash) begin
                            r_squash     <= 1'b0;
                            r_instr_data <= INSTR_NOP;
                            r_state      <= S_REQ;
                        end else if (imem_err) begin
                            r_fetch_fault <= 1'b1;
                            r_fault_cause <= 2'b10;
                            r_state       <= S_FAULT;
                        end else begin
                            r_instr_data  <= imem_rdata;
                            r_instr_pc    <= pc;
                            r_instr_valid <= 1'b1;
                            r_state       <= S_HOLD;
                        end
                    end
                end

                S_HOLD: begin
                    if (redirect_valid) begin
                        // redirect wins over a same-cycle accept: drop the instruction
                        r_instr_valid <= 1'b0;
                        r_instr_data  <= INSTR_NOP;
                        r_state       <= S_REQ;
                    end else if (instr_ready) begin
                        r_instr_valid <= 1'b0;
                        r_state       <= S_REQ;
                    end
                end

                S_FAULT: begin
                    if (redirect_valid) begin
                        r_fetch_fault <= 1'b0;
                        r_fault_cause <= 2'b00;
                        r_state       <= S_REQ;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rvm_ifu.sv
// Purpose : directed bench for rvm_ifu with a transaction-level reference model and per-cycle compare.
// Latency : n/a (bench).
// Backpressure: decode ready and memory gnt/rvalid driven by directed vectors.

module tb_rvm_ifu;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk;
    logic        resetn;
    logic [31:0] pc;
    logic [1:0]  pc_w_en;
    logic [31:0] pc_wdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        imem_err;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        fetch_fault;
    logic [1:0]  fault_cause;

    int n_chk = 0;
    int n_err = 0;

    rvm_ifu #(.INSTR_NOP(NOP), .FAULT_ON_MISALIGN(1)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .pc              (pc),
        .pc_w_en         (pc_w_en),
        .pc_wdata        (pc_wdata),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .imem_err        (imem_err),
        .instr_valid     (instr_valid),
        .instr_data      (instr_data),
        .instr_pc        (instr_pc),
        .instr_ready     (instr_ready),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .fetch_fault     (fetch_fault),
        .fault_cause     (fault_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PC unit: applies any write at the same edge
    always @(posedge clk or negedge resetn) begin
        if (!resetn)                                pc <= 32'd0;
        else if (pc_w_en == 2'b01 || pc_w_en == 2'b10) pc <= pc_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks the fetch as a set of facts rather than a state number:
    // boot cycle pending, a granted request outstanding, its response to be
    // dropped, an instruction held for decode, and a sticky fault code.
    logic        m_boot, m_busy, m_drop, m_have;
    logic [1:0]  m_fault;
    logic [31:0] m_data, m_ipc;
    logic        m_requesting, m_exp_req;
    logic [1:0]  m_exp_wen;
    logic [31:0] m_exp_wdata;

    always @(negedge clk) begin
        if (!resetn) begin
            m_boot = 1'b1; m_busy = 1'b0; m_drop = 1'b0; m_have = 1'b0;
            m_fault = 2'b00; m_data = NOP; m_ipc = 32'd0;
            chk("rst_req",   imem_req,    0);
            chk("rst_wen",   pc_w_en,     0);
            chk("rst_wdata", pc_wdata,    0);
            chk("rst_valid", instr_valid, 0);
            chk("rst_data",  instr_data,  NOP);
            chk("rst_ipc",   instr_pc,    0);
            chk("rst_fault", fetch_fault, 0);
            chk("rst_cause", fault_cause, 0);
        end else begin
            m_requesting = !m_boot && !m_busy && !m_have && (m_fault == 2'b00);
            m_exp_req    = m_requesting && (pc[1:0] == 2'b00);
            if (redirect_valid) begin
                m_exp_wen = 2'b10; m_exp_wdata = redirect_target;
            end else if (m_have && instr_ready) begin
                m_exp_wen = 2'b01; m_exp_wdata = pc + 32'd4;
            end else begin
                m_exp_wen = 2'b00; m_exp_wdata = 32'd0;
            end

            chk("m_req", imem_req, m_exp_req);
            if (m_exp_req) chk("m_addr", imem_addr, pc);
            chk("m_wen",   pc_w_en,  m_exp_wen);
            chk("m_wdata", pc_wdata, m_exp_wdata);
            chk("m_valid", instr_valid, m_have);
            if (m_have) begin
                chk("m_data", instr_data, m_data);
                chk("m_ipc",  instr_pc,   m_ipc);
            end
            chk("m_fault", fetch_fault, m_fault != 2'b00);
            chk("m_cause", fault_cause, m_fault);

            // advance the model to what the next edge must produce
            if (m_boot) begin
                m_boot = 1'b0;
            end else if (m_fault != 2'b00) begin
                if (redirect_valid) m_fault = 2'b00;
            end else if (m_have) begin
                if (redirect_valid || instr_ready) m_have = 1'b0;
            end else if (m_busy) begin
                if (redirect_valid) begin
                    if (imem_rvalid) begin m_busy = 1'b0; m_drop = 1'b0; end
                    else m_drop = 1'b1;
                end else if (imem_rvalid) begin
                    m_busy = 1'b0;
                    if (m_drop) m_drop = 1'b0;
                    else if (imem_err) m_fault = 2'b10;
                    else begin m_have = 1'b1; m_data = imem_rdata; m_ipc = pc; end
                end
            end else begin
                if (redirect_valid) begin
                    if (m_exp_req && imem_gnt) begin m_busy = 1'b1; m_drop = 1'b1; end
                end else if (pc[1:0] != 2'b00) begin
                    m_fault = 2'b01;
                end else if (imem_gnt) begin
                    m_busy = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        resetn = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
        imem_err = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_target = 32'd0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        // basic fetch with immediate gnt/rvalid and ready
        @(negedge clk); chk("t1_idle_req", imem_req, 0);
        tick(); imem_gnt = 1'b1;
        @(negedge clk); chk("t1_req", imem_req, 1); chk("t1_addr", imem_addr, 32'h0);
        tick(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h00500093;
        tick(); imem_rvalid = 1'b0; instr_ready = 1'b1;
        @(negedge clk);
        chk("t1_valid", instr_valid, 1); chk("t1_ipc", instr_pc, 32'h0);
        chk("t1_data", instr_data, 32'h00500093);
        chk("t1_wen", pc_w_en, 2'b01); chk("t1_wdata", pc_wdata, 32'h4);
        tick(); instr_ready = 1'b0;

        // decode backpressure for 5 cycles
        imem_gnt = 1'b1;
        @(negedge clk); chk("t2_addr", imem_addr, 32'h4);
        tick(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h00A00113;
        tick(); imem_rvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_bp_wen", pc_w_en, 2'b00); chk("t2_bp_data", instr_data, 32'h00A00113);
            chk("t2_bp_ipc", instr_pc, 32'h4);
            tick();
        end
        instr_ready = 1'b1;
        @(negedge clk); chk("t2_wen", pc_w_en, 2'b01); chk("t2_wdata", pc_wdata, 32'h8);
        tick(); instr_ready = 1'b0;

        // redirect while waiting; the late response must be discarded
        imem_gnt = 1'b1;
        tick(); imem_gnt = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h100;
        @(negedge clk); chk("t3_wen", pc_w_en, 2'b10); chk("t3_wdata", pc_wdata, 32'h100);
        tick(); redirect_valid = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEADBEEF;
        tick(); imem_rvalid = 1'b0;
        @(negedge clk);
        chk("t3_req", imem_req, 1); chk("t3_addr", imem_addr, 32'h100); chk("t3_valid", instr_valid, 0);
        tick(); imem_gnt = 1'b1;
        tick(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h00108093;
        tick(); imem_rvalid = 1'b0;

        // redirect and ready together in HOLD: redirect only
        instr_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h180;
        @(negedge clk);
        chk("t4_valid", instr_valid, 1); chk("t4_ipc", instr_pc, 32'h100);
        chk("t4_wen", pc_w_en, 2'b10); chk("t4_wdata", pc_wdata, 32'h180);
        tick(); instr_ready = 1'b0; redirect_valid = 1'b0;
        @(negedge clk); chk("t4_drop", instr_valid, 0); chk("t4_addr", imem_addr, 32'h180);

        // misaligned PC fault, cleared by redirect
        tick(); redirect_valid = 1'b1; redirect_target = 32'h102;
        tick(); redirect_valid = 1'b0;
        @(negedge clk); chk("t5_noreq", imem_req, 0);
        tick();
        @(negedge clk); chk("t5_fault", fetch_fault, 1); chk("t5_cause", fault_cause, 2'b01);
        tick(); tick(); redirect_valid = 1'b1; redirect_target = 32'h200;
        @(negedge clk); chk("t5_sticky", fetch_fault, 1);
        tick(); redirect_valid = 1'b0;
        @(negedge clk);
        chk("t5_clr", fetch_fault, 0); chk("t5_cclr", fault_cause, 0);
        chk("t5_req", imem_req, 1); chk("t5_addr", imem_addr, 32'h200);

        // bus error
        tick(); imem_gnt = 1'b1;
        tick(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_err = 1'b1; imem_rdata = 32'h12345678;
        tick(); imem_rvalid = 1'b0; imem_err = 1'b0;
        @(negedge clk);
        chk("t6_fault", fetch_fault, 1); chk("t6_cause", fault_cause, 2'b10); chk("t6_valid", instr_valid, 0);

        // PC wrap at the top of the address space
        tick(); redirect_valid = 1'b1; redirect_target = 32'hFFFFFFFC;
        tick(); redirect_valid = 1'b0; imem_gnt = 1'b1;
        tick(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h00000073;
        tick(); imem_rvalid = 1'b0; instr_ready = 1'b1;
        @(negedge clk);
        chk("t7_ipc", instr_pc, 32'hFFFFFFFC); chk("t7_wen", pc_w_en, 2'b01); chk("t7_wdata", pc_wdata, 32'h0);
        tick(); instr_ready = 1'b0;

        // redirect coincident with rvalid in WAIT
        imem_gnt = 1'b1;
        tick(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEADBEEF;
        redirect_valid = 1'b1; redirect_target = 32'h300;
        tick(); imem_rvalid = 1'b0; redirect_valid = 1'b0;
        @(negedge clk);
        chk("t8_req", imem_req, 1); chk("t8_addr", imem_addr, 32'h300); chk("t8_valid", instr_valid, 0);

        // reset while waiting; stale response afterwards must be ignored
        tick(); imem_gnt = 1'b1;
        tick(); imem_gnt = 1'b0; resetn = 1'b0;
        @(negedge clk);
        chk("t9_req", imem_req, 0); chk("t9_wen", pc_w_en, 0); chk("t9_valid", instr_valid, 0);
        chk("t9_data", instr_data, NOP);
        tick(); resetn = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0BAD0;
        tick();
        tick(); imem_rvalid = 1'b0;
        @(negedge clk);
        chk("t9_stale", instr_valid, 0); chk("t9_req2", imem_req, 1); chk("t9_addr", imem_addr, 32'h0);
        tick(); imem_gnt = 1'b1;
        tick(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h00200093;
        tick(); imem_rvalid = 1'b0;
        @(negedge clk); chk("t9_fetch", instr_data, 32'h00200093); chk("t9_fv", instr_valid, 1);
        tick(); instr_ready = 1'b1;
        tick(); instr_ready = 1'b0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
